// File: rtl/corr_pkg.sv
// Shared constants and types for the correlator sweep controller.
// Optional feature macro: CORR_DROP_CNT_EN (per-integration drop counter).
package corr_pkg;

    // Number of lags; equals the depth of the shift RAM.
    localparam int LAGS   = 64;
    // Lag index width, clog2(LAGS).
    localparam int LAG_W  = 6;
    // Cycles from the sr_sin pulse to the first valid shifted word (>= 2).
    localparam int SR_LAT = 2;
    // Width of the integration-length counter.
    localparam int INT_W  = 16;
    // Width of the latency down-counter.
    localparam int LAT_W  = 2;
    // Width of the saturating drop counter.
    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATENCY = 2'd1,
        SWEEP   = 2'd2
    } corr_state_t;

    // An integration length of 0 behaves as 1.
    function automatic logic [INT_W-1:0] eff_len(input logic [INT_W-1:0] len);
        logic [INT_W-1:0] one;
        one = INT_W'(1);
        return (len == '0) ? one : len;
    endfunction

endpackage

// File: rtl/corr_int_counter.sv
// Integration bookkeeping for the correlator sweep controller: counts
// accepted samples, latches the integration length at the first sample,
// flags the first sweep of an integration and pulses dump when the
// integration completes. Integrations touched by enable=0 are discarded.
// Optional feature macro: CORR_DROP_CNT_EN (per-integration drop counter).
module corr_int_counter
    import corr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [INT_W-1:0]  int_len,
    input  logic              accept,
    input  logic              busy,
    input  logic              sweep_last,
    output logic              first,
`ifdef CORR_DROP_CNT_EN
    input  logic              drop,
    output logic [DROP_W-1:0] drop_cnt,
`endif
    output logic              dump
);

    logic [INT_W-1:0] count;
    logic [INT_W-1:0] len_q;
    logic             first_q;
    logic             abort_q;
    logic             dump_q;
    logic             discard;
    logic             dump_now;

    // A sweep that saw enable low at any point throws away the integration.
    assign discard  = abort_q | ~enable;
    // The final sweep of a complete integration ends this cycle.
    assign dump_now = sweep_last & ~discard & (count == len_q);

    assign first = first_q;
    assign dump  = dump_q;

    // Sample count, length latch, first-sweep flag, abort tracking and dump pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
            abort_q <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            dump_q <= 1'b0;
            if (accept) begin
                // count==0 means this sample opens a new integration
                if (count == '0) begin
                    len_q   <= eff_len(int_len);
                    first_q <= 1'b1;
                end else begin
                    first_q <= 1'b0;
                end
                count <= count + INT_W'(1);
            end else if (sweep_last) begin
                abort_q <= 1'b0;
                if (discard) begin
                    count <= '0;
                end else if (dump_now) begin
                    count  <= '0;
                    dump_q <= 1'b1;
                end
            end else if (!busy && !enable) begin
                // disabled between sweeps: any partial integration is dropped
                count <= '0;
            end
            if (busy && !enable && !sweep_last) begin
                abort_q <= 1'b1;
            end
        end
    end

`ifdef CORR_DROP_CNT_EN
    logic [DROP_W-1:0] drop_ctr;
    logic [DROP_W-1:0] drop_sum;

    // Saturating increment of the running drop count.
    always_comb begin
        drop_sum = drop_ctr;
        if (drop && (drop_ctr != {DROP_W{1'b1}})) begin
            drop_sum = drop_ctr + DROP_W'(1);
        end
    end

    // Running drop count per integration; published and cleared at dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_ctr <= '0;
            drop_cnt <= '0;
        end else if (dump_now) begin
            drop_cnt <= drop_sum;
            drop_ctr <= '0;
        end else if ((sweep_last && discard) || (!busy && !enable)) begin
            drop_ctr <= '0;
        end else begin
            drop_ctr <= drop_sum;
        end
    end
`endif

endmodule

// File: rtl/corr_sweep_ctrl.sv
// Sequencer for the RAM-based shift register of the correlator datapath.
// Accepts an ADC sample, pulses the shift RAM sync input, waits out the RAM
// latency and then sweeps lag_idx from LAGS-1 down to 0 with acc_en high,
// while corr_int_counter tracks integrations and raises dump.
// Optional feature macro: CORR_DROP_CNT_EN (adds the drop_cnt output).
//
// Handshake: a sample is accepted in any cycle where s_valid and s_ready
// are both high (sr_sin is exactly that product). The ADC is free-running
// and never holds a sample, so s_valid with s_ready low is a lost sample.
module corr_sweep_ctrl
    import corr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [INT_W-1:0]  int_len,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              sr_sin,
    output logic [LAG_W-1:0]  lag_idx,
    output logic              acc_en,
    output logic              acc_first,
    output logic              dump,
    output logic              busy,
    output logic              overrun,
`ifdef CORR_DROP_CNT_EN
    output logic [DROP_W-1:0] drop_cnt,
`endif
    output corr_state_t       dbg_state
);

    corr_state_t      state;
    corr_state_t      state_nxt;
    logic [LAG_W-1:0] lag_cnt;
    logic [LAG_W-1:0] lag_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_nxt;
    logic             accept;
    logic             drop;
    logic             sweep_last;
    logic             enable_q;
    logic             first;

    // rst_n gates s_ready so every output is low while reset is held.
    assign s_ready   = rst_n & enable & (state == IDLE);
    assign sr_sin    = s_valid & s_ready;
    assign accept    = sr_sin;
    assign drop      = s_valid & ~s_ready;

    assign acc_en    = (state == SWEEP);
    assign lag_idx   = acc_en ? lag_cnt : '0;
    assign acc_first = acc_en & first;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register with the lag and latency counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lag_cnt <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lag_cnt <= lag_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    // Next state: IDLE -> LATENCY (SR_LAT-1 cycles) -> SWEEP (LAGS cycles) -> IDLE.
    always_comb begin
        state_nxt  = state;
        lag_nxt    = lag_cnt;
        lat_nxt    = lat_cnt;
        sweep_last = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LATENCY;
                    lat_nxt   = LAT_W'(SR_LAT - 2);
                    lag_nxt   = LAG_W'(LAGS - 1);
                end
            end
            LATENCY: begin
                if (lat_cnt == '0) begin
                    state_nxt = SWEEP;
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end
            SWEEP: begin
                // the sweep cannot be aborted; it always runs to lag 0
                if (lag_cnt == '0) begin
                    sweep_last = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    lag_nxt = lag_cnt - LAG_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sticky drop flag; a rising edge of enable clears it unless a drop lands then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            enable_q <= enable;
            if (drop) begin
                overrun <= 1'b1;
            end else if (enable && !enable_q) begin
                overrun <= 1'b0;
            end
        end
    end

    corr_int_counter u_int_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .int_len    (int_len),
        .accept     (accept),
        .busy       (busy),
        .sweep_last (sweep_last),
        .first      (first),
`ifdef CORR_DROP_CNT_EN
        .drop       (drop),
        .drop_cnt   (drop_cnt),
`endif
        .dump       (dump)
    );

endmodule

// File: tb/tb_corr_sweep_ctrl.sv
// Bench for corr_sweep_ctrl: cycle-arithmetic model of the sweep timing and
// integration rules, checked every cycle, plus hand-computed literal points.
`timescale 1ns/1ps
module tb_corr_sweep_ctrl;
    import corr_pkg::*;

    localparam int PERIOD = SR_LAT + LAGS;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             s_valid = 1'b0;
    logic [INT_W-1:0] int_len = '0;
    logic             s_ready, sr_sin, acc_en, acc_first, dump, busy, overrun;
    logic [LAG_W-1:0] lag_idx;
    corr_state_t      dbg_state;
`ifdef CORR_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    corr_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .int_len   (int_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sr_sin    (sr_sin),
        .lag_idx   (lag_idx),
        .acc_en    (acc_en),
        .acc_first (acc_first),
        .dump      (dump),
        .busy      (busy),
        .overrun   (overrun),
`ifdef CORR_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    int   m_a = 0;          // cycle of the last accepted sample
    bit   m_have = 0;       // at least one sample accepted since reset
    int   m_cnt = 0;        // samples in the open integration
    int   m_len = 0;        // latched integration length
    bit   m_first = 0;      // current sweep opens an integration
    bit   m_abort = 0;      // enable seen low during the current sweep
    int   m_dump_at = -1;   // cycle in which dump must be high
    bit   m_ovr = 0;
    bit   m_en_prev = 0;
    int   m_drops = 0;
    int   m_drop_cnt = 0;

    int   rel;
    bit   e_busy, e_acc, e_ready, e_sin, e_first, e_dump, drop_now, last_now, disc;
    int   e_lag, e_state;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_have = 0; m_cnt = 0; m_len = 0; m_first = 0; m_abort = 0;
            m_dump_at = -1; m_ovr = 0; m_en_prev = 0; m_drops = 0; m_drop_cnt = 0;
            check("rst_s_ready", s_ready, 0);
            check("rst_sr_sin", sr_sin, 0);
            check("rst_acc_en", acc_en, 0);
            check("rst_acc_first", acc_first, 0);
            check("rst_lag_idx", lag_idx, 0);
            check("rst_dump", dump, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
`ifdef CORR_DROP_CNT_EN
            check("rst_drop_cnt", drop_cnt, 0);
`endif
        end else begin
            rel     = cyc - m_a;
            e_busy  = m_have && rel >= 1 && rel <= PERIOD - 1;
            e_acc   = m_have && rel >= SR_LAT && rel <= PERIOD - 1;
            e_lag   = e_acc ? (PERIOD - 1 - rel) : 0;
            e_ready = enable && !e_busy;
            e_sin   = s_valid && e_ready;
            e_first = e_acc && m_first;
            e_dump  = (cyc == m_dump_at);
            e_state = !e_busy ? 32'(IDLE) : (e_acc ? 32'(SWEEP) : 32'(LATENCY));

            check("s_ready", s_ready, e_ready);
            check("sr_sin", sr_sin, e_sin);
            check("acc_en", acc_en, e_acc);
            check("acc_first", acc_first, e_first);
            check("lag_idx", lag_idx, e_lag);
            check("dump", dump, e_dump);
            check("busy", busy, e_busy);
            check("overrun", overrun, m_ovr);
            check("state", 32'(dbg_state), e_state);
`ifdef CORR_DROP_CNT_EN
            check("drop_cnt", drop_cnt, m_drop_cnt);
`endif
            // advance the model to the next cycle
            drop_now = s_valid && !e_ready;
            if (drop_now && m_drops < 65535) m_drops++;
            if (drop_now) m_ovr = 1;
            else if (enable && !m_en_prev) m_ovr = 0;
            if (e_sin) begin
                if (m_cnt == 0) begin
                    m_len   = (int_len == 0) ? 1 : int'(int_len);
                    m_first = 1;
                end else begin
                    m_first = 0;
                end
                m_cnt++;
                m_a    = cyc;
                m_have = 1;
            end
            if (e_busy && !enable) m_abort = 1;
            last_now = m_have && rel == PERIOD - 1;
            if (last_now) begin
                disc = m_abort;
                m_abort = 0;
                if (disc) begin
                    m_cnt = 0; m_drops = 0;
                end else if (m_cnt == m_len) begin
                    m_dump_at  = cyc + 1;
                    m_drop_cnt = m_drops;
                    m_cnt = 0; m_drops = 0;
                end
            end
            if (!e_busy && !enable) begin
                m_cnt = 0; m_drops = 0;
            end
            m_en_prev = enable;
        end
    end

    // ---------------- driver ----------------
    task automatic gap();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            enable = 1'b0; s_valid = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; int_len = 16'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lit_reset_busy", busy, 0);
        check("lit_reset_state", 32'(dbg_state), 32'(IDLE));

        // 1: single sample at 10, int_len=1
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b1; enable = 1'b1; s_valid = (i == 10);
            @(negedge clk);
            if (i == 10) check("s1_sr_sin", sr_sin, 1);
            if (i == 11) check("s1_acc_en_pre", acc_en, 0);
            if (i == 12) begin
                check("s1_acc_en_start", acc_en, 1);
                check("s1_lag_first", lag_idx, 63);
                check("s1_first", acc_first, 1);
            end
            if (i == 75) begin
                check("s1_acc_en_end", acc_en, 1);
                check("s1_lag_last", lag_idx, 0);
            end
            if (i == 76) begin
                check("s1_acc_en_off", acc_en, 0);
                check("s1_dump", dump, 1);
                check("s1_s_ready", s_ready, 1);
            end
            if (i == 77) check("s1_dump_off", dump, 0);
        end
        gap();

        // 2: int_len=3, a sample every sweep period
        int_len = 16'd3;
        for (int i = 0; i < 270; i++) begin
            @(posedge clk); #1;
            enable = 1'b1; s_valid = (i % PERIOD == 0) && (i <= 198);
            @(negedge clk);
            if (i == 2)   check("s2_first_sw1", acc_first, 1);
            if (i == 68)  check("s2_first_sw2", acc_first, 0);
            if (i == 134) check("s2_first_sw3", acc_first, 0);
            if (i == 132) check("s2_no_dump", dump, 0);
            if (i == 198) begin
                check("s2_dump", dump, 1);
                check("s2_accept_in_dump", sr_sin, 1);
            end
            if (i == 200) check("s2_first_sw4", acc_first, 1);
        end
        gap();

        // 3: s_valid held for 200 cycles, int_len=3
        for (int i = 0; i < 270; i++) begin
            @(posedge clk); #1;
            enable = 1'b1; s_valid = (i < 200);
            @(negedge clk);
            if (i == 1)   check("s3_ovr_pre", overrun, 0);
            if (i == 2)   check("s3_ovr", overrun, 1);
            if (i == 66)  check("s3_acc66", sr_sin, 1);
            if (i == 65)  check("s3_drop65", sr_sin, 0);
            if (i == 198) begin
                check("s3_dump", dump, 1);
`ifdef CORR_DROP_CNT_EN
                check("s3_drop_cnt", drop_cnt, 195);
`endif
            end
        end
        gap();

        // 4: enable dropped at A+20
        int_len = 16'd2;
        for (int i = 0; i < 220; i++) begin
            @(posedge clk); #1;
            enable  = !(i >= 20 && i < 80);
            s_valid = (i == 0) || (i == 70) || (i == 82) || (i == 148);
            @(negedge clk);
            if (i == 65) check("s4_acc_en_end", acc_en, 1);
            if (i == 66) begin
                check("s4_acc_en_off", acc_en, 0);
                check("s4_no_dump", dump, 0);
                check("s4_s_ready", s_ready, 0);
            end
            if (i == 71)  check("s4_ovr", overrun, 1);
            if (i == 81)  check("s4_ovr_clr", overrun, 0);
            if (i == 84)  check("s4_first_after", acc_first, 1);
            if (i == 148) check("s4_no_dump2", dump, 0);
            if (i == 214) check("s4_dump", dump, 1);
        end
        gap();

        // 5: reset at A+30 mid-sweep, then a clean sample
        int_len = 16'd1;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk); #1;
            rst_n = !(i >= 35 && i < 38); enable = 1'b1;
            s_valid = (i == 5) || (i == 48);
            @(negedge clk);
            if (i == 34) check("s5_acc_pre", acc_en, 1);
            if (i == 35) begin
                check("s5_acc_rst", acc_en, 0);
                check("s5_busy_rst", busy, 0);
                check("s5_ready_rst", s_ready, 0);
            end
            if (i == 50) check("s5_lag_first", lag_idx, 63);
            if (i == 113) check("s5_lag_last", lag_idx, 0);
            if (i == 114) check("s5_dump", dump, 1);
        end
        gap();

        // 6a: int_len=0 behaves as 1
        int_len = 16'd0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            enable = 1'b1; s_valid = (i == 0);
            @(negedge clk);
            if (i == 66) check("s6_len0_dump", dump, 1);
        end
        gap();

        // 6b: int_len change mid-integration is ignored
        for (int i = 0; i < 140; i++) begin
            @(posedge clk); #1;
            enable = 1'b1; int_len = (i < 10) ? 16'd2 : 16'd1;
            s_valid = (i == 0) || (i == 66);
            @(negedge clk);
            if (i == 66)  check("s6_chg_no_dump", dump, 0);
            if (i == 132) check("s6_chg_dump", dump, 1);
        end
        gap();

        // 6c: int_len=65535 does not dump after a few samples
        int_len = 16'hFFFF;
        for (int i = 0; i < 140; i++) begin
            @(posedge clk); #1;
            enable = 1'b1; s_valid = (i == 0) || (i == 66);
            @(negedge clk);
            if (i == 66)  check("s6_max_no_dump1", dump, 0);
            if (i == 132) check("s6_max_no_dump2", dump, 0);
        end
        gap();

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
